// File: rtl/fp32_add_unit.sv
// Multi-cycle binary32 adder: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE with a valid/acknowledge handshake.
// Define FPADD_SUBTRACT_EN to let Mode[2] turn the operation into A - B.
module fp32_add_unit #(
  parameter int LATENCY = 5
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] Datain1,
  input  logic [31:0] Datain2,
  input  logic        Data_valid,
  input  logic [2:0]  Mode,
  input  logic [4:0]  Debug,
  output logic [31:0] Dataout,
  output logic        Dataout_valid,
  output logic [2:0]  Exc
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [2:0]  EXC_NONE  = 3'b000;
  localparam logic [2:0]  EXC_OVF   = 3'b001;
  localparam logic [2:0]  EXC_UNF   = 3'b010;
  localparam logic [2:0]  EXC_INV   = 3'b011;
  localparam logic [2:0]  EXC_INF   = 3'b100;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;

  state_t       state_r, state_nxt_s;

  logic [31:0]  opa_r, opb_r;
  logic [1:0]   rmode_r;

  logic         sx_r, sub_r;
  logic [7:0]   ex_r;
  logic [26:0]  mx_r, my_r;
  logic         spec_hit_r;
  logic [2:0]   spec_exc_r;
  logic [31:0]  spec_res_r;

  logic [27:0]  sum_r;
  logic [26:0]  norm_man_r;
  logic [9:0]   norm_exp_r;
  logic         zero_r;

  logic         unused_s;
  assign unused_s = ^{Debug, Mode[2], LATENCY[0]};

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = Data_valid ? ST_ALIGN : ST_IDLE;
      ST_ALIGN: state_nxt_s = ST_ADD;
      ST_ADD:   state_nxt_s = ST_NORM;
      ST_NORM:  state_nxt_s = ST_ROUND;
      ST_ROUND: state_nxt_s = ST_DONE;
      ST_DONE:  state_nxt_s = Data_valid ? ST_DONE : ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // ---------------- ALIGN: unpack, classify, swap, shift ----------------
  logic        sa_s, sb_s, nan_a_s, nan_b_s, inf_a_s, inf_b_s;
  logic [7:0]  ea_s, eb_s, ex_s, ey_s, exp_diff_s;
  logic [23:0] ma_s, mb_s, mx_s, my_s;
  logic        sx_s, a_ge_b_s;
  logic [26:0] ext_y_s, shifted_s, aligned_s;
  logic        lost_s;
  logic [4:0]  sh_s;
  logic        spec_hit_s;
  logic [2:0]  spec_exc_s;
  logic [31:0] spec_res_s;

  // Operand unpacking and special-case classification; exponent 0 reads as zero.
  always_comb begin
    sa_s    = opa_r[31];
    sb_s    = opb_r[31];
    ea_s    = opa_r[30:23];
    eb_s    = opb_r[30:23];
    nan_a_s = (ea_s == 8'hFF) && (opa_r[22:0] != 23'd0);
    nan_b_s = (eb_s == 8'hFF) && (opb_r[22:0] != 23'd0);
    inf_a_s = (ea_s == 8'hFF) && (opa_r[22:0] == 23'd0);
    inf_b_s = (eb_s == 8'hFF) && (opb_r[22:0] == 23'd0);
    ma_s    = (ea_s == 8'd0) ? 24'd0 : {1'b1, opa_r[22:0]};
    mb_s    = (eb_s == 8'd0) ? 24'd0 : {1'b1, opb_r[22:0]};
    spec_hit_s = 1'b0;
    spec_exc_s = EXC_NONE;
    spec_res_s = 32'd0;
    if (nan_a_s || nan_b_s || (inf_a_s && inf_b_s && (sa_s != sb_s))) begin
      spec_hit_s = 1'b1;
      spec_exc_s = EXC_INV;
      spec_res_s = QNAN;
    end else if (inf_a_s) begin
      spec_hit_s = 1'b1;
      spec_exc_s = EXC_INF;
      spec_res_s = {sa_s, 8'hFF, 23'd0};
    end else if (inf_b_s) begin
      spec_hit_s = 1'b1;
      spec_exc_s = EXC_INF;
      spec_res_s = {sb_s, 8'hFF, 23'd0};
    end else begin
      spec_hit_s = 1'b0;
    end
  end

  // Swap so X holds the larger magnitude, then align Y with guard/round/sticky.
  always_comb begin
    a_ge_b_s   = {ea_s, ma_s} >= {eb_s, mb_s};
    sx_s       = a_ge_b_s ? sa_s : sb_s;
    ex_s       = a_ge_b_s ? ea_s : eb_s;
    ey_s       = a_ge_b_s ? eb_s : ea_s;
    mx_s       = a_ge_b_s ? ma_s : mb_s;
    my_s       = a_ge_b_s ? mb_s : ma_s;
    exp_diff_s = ex_s - ey_s;
    ext_y_s    = {my_s, 3'b000};
    sh_s       = exp_diff_s[4:0];
    shifted_s  = ext_y_s >> sh_s;
    lost_s     = |(ext_y_s & ~({27{1'b1}} << sh_s));
    if (exp_diff_s >= 8'd26) begin
      aligned_s = {26'd0, |my_s};
    end else begin
      aligned_s = {shifted_s[26:1], shifted_s[0] | lost_s};
    end
  end

  // ---------------- ADD ----------------
  logic [27:0] sum_s;

  // Magnitude add or subtract; X >= Y so the difference is never negative.
  always_comb begin
    if (sub_r) begin
      sum_s = {1'b0, mx_r} - {1'b0, my_r};
    end else begin
      sum_s = {1'b0, mx_r} + {1'b0, my_r};
    end
  end

  // ---------------- NORM ----------------
  logic [4:0]  lzc_s;
  logic [26:0] norm_man_s;
  logic [9:0]  norm_exp_s;

  // Leading-zero count of the non-carry field; the highest set bit wins.
  always_comb begin
    lzc_s = 5'd27;
    for (int i = 0; i < 27; i++) begin
      lzc_s = sum_r[i] ? 5'(26 - i) : lzc_s;
    end
  end

  // Normalise: carry shifts right into sticky, otherwise shift out leading zeros.
  always_comb begin
    if (sum_r[27]) begin
      norm_man_s = {sum_r[27:2], sum_r[1] | sum_r[0]};
      norm_exp_s = {2'b00, ex_r} + 10'd1;
    end else begin
      norm_man_s = sum_r[26:0] << lzc_s;
      norm_exp_s = {2'b00, ex_r} - {5'd0, lzc_s};
    end
  end

  // ---------------- ROUND ----------------
  logic [23:0] mant24_s;
  logic        g_s, r_s, s_s, inexact_s, up_s, inf_sel_s;
  logic [24:0] rounded_s;
  logic [22:0] frac_s;
  logic [9:0]  res_exp_s;
  logic [31:0] res_s;
  logic [2:0]  exc_s;

  // Rounding increment per mode.
  always_comb begin
    mant24_s  = norm_man_r[26:3];
    g_s       = norm_man_r[2];
    r_s       = norm_man_r[1];
    s_s       = norm_man_r[0];
    inexact_s = g_s | r_s | s_s;
    case (rmode_r)
      2'b00:   up_s = g_s & (r_s | s_s | mant24_s[0]);
      2'b01:   up_s = 1'b0;
      2'b10:   up_s = ~sx_r & inexact_s;
      2'b11:   up_s = sx_r & inexact_s;
      default: up_s = 1'b0;
    endcase
    case (rmode_r)
      2'b00:   inf_sel_s = 1'b1;
      2'b01:   inf_sel_s = 1'b0;
      2'b10:   inf_sel_s = ~sx_r;
      2'b11:   inf_sel_s = sx_r;
      default: inf_sel_s = 1'b1;
    endcase
    rounded_s = {1'b0, mant24_s} + {24'd0, up_s};
    if (rounded_s[24]) begin
      frac_s    = rounded_s[23:1];
      res_exp_s = norm_exp_r + 10'd1;
    end else begin
      frac_s    = rounded_s[22:0];
      res_exp_s = norm_exp_r;
    end
  end

  // Result selection: specials, then zero, overflow, underflow, normal.
  always_comb begin
    res_s = {sx_r, res_exp_s[7:0], frac_s};
    exc_s = EXC_NONE;
    if (spec_hit_r) begin
      res_s = spec_res_r;
      exc_s = spec_exc_r;
    end else if (zero_r) begin
      res_s = {(sub_r ? (rmode_r == 2'b11) : sx_r), 31'd0};
      exc_s = EXC_NONE;
    end else if ($signed(res_exp_s) >= $signed(10'd255)) begin
      res_s = inf_sel_s ? {sx_r, 8'hFF, 23'd0} : {sx_r, 8'hFE, 23'h7F_FFFF};
      exc_s = EXC_OVF;
    end else if ($signed(norm_exp_r) < $signed(10'd1)) begin
      res_s = {sx_r, 31'd0};
      exc_s = EXC_UNF;
    end else begin
      res_s = {sx_r, res_exp_s[7:0], frac_s};
      exc_s = EXC_NONE;
    end
  end

  // Datapath pipeline registers, each loaded in its own state.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      opa_r      <= 32'd0;
      opb_r      <= 32'd0;
      rmode_r    <= 2'b00;
      sx_r       <= 1'b0;
      sub_r      <= 1'b0;
      ex_r       <= 8'd0;
      mx_r       <= 27'd0;
      my_r       <= 27'd0;
      spec_hit_r <= 1'b0;
      spec_exc_r <= 3'b000;
      spec_res_r <= 32'd0;
      sum_r      <= 28'd0;
      norm_man_r <= 27'd0;
      norm_exp_r <= 10'd0;
      zero_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Data_valid) begin
            opa_r   <= Datain1;
`ifdef FPADD_SUBTRACT_EN
            opb_r   <= {Datain2[31] ^ Mode[2], Datain2[30:0]};
`else
            opb_r   <= Datain2;
`endif
            rmode_r <= Mode[1:0];
          end
        end
        ST_ALIGN: begin
          sx_r       <= sx_s;
          sub_r      <= sa_s ^ sb_s;
          ex_r       <= ex_s;
          mx_r       <= {mx_s, 3'b000};
          my_r       <= aligned_s;
          spec_hit_r <= spec_hit_s;
          spec_exc_r <= spec_exc_s;
          spec_res_r <= spec_res_s;
        end
        ST_ADD: begin
          sum_r <= sum_s;
        end
        ST_NORM: begin
          norm_man_r <= norm_man_s;
          norm_exp_r <= norm_exp_s;
          zero_r     <= (sum_r == 28'd0);
        end
        default: begin
          sum_r <= sum_r;
        end
      endcase
    end
  end

  // Output registers: loaded in ROUND, acknowledge held through DONE.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Dataout       <= 32'd0;
      Dataout_valid <= 1'b0;
      Exc           <= 3'b000;
    end else begin
      case (state_r)
        ST_ROUND: begin
          Dataout       <= res_s;
          Exc           <= exc_s;
          Dataout_valid <= 1'b1;
        end
        ST_DONE: begin
          Dataout_valid <= Data_valid;
        end
        default: begin
          Dataout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_add_unit.sv
// Scoreboard bench for fp32_add_unit: directed vectors push expectations, a monitor pops on each new result.
module tb_fp32_add_unit;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] Datain1, Datain2;
  logic        Data_valid;
  logic [2:0]  Mode;
  logic [4:0]  Debug;
  logic [31:0] Dataout;
  logic        Dataout_valid;
  logic [2:0]  Exc;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  exc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  logic prev_valid = 1'b0;

  fp32_add_unit dut (
    .CLK(CLK), .RSTn(RSTn), .Datain1(Datain1), .Datain2(Datain2),
    .Data_valid(Data_valid), .Mode(Mode), .Debug(Debug),
    .Dataout(Dataout), .Dataout_valid(Dataout_valid), .Exc(Exc)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: each rising Dataout_valid consumes one scoreboard entry.
  always @(negedge CLK) begin
    if (Dataout_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h with no pending request", Dataout);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, " data"}, Dataout, e.res);
        check({e.name, " exc"}, {29'd0, Exc}, {29'd0, e.exc});
      end
    end
    prev_valid = Dataout_valid;
  end

  // Issue one request; latency counts edges from the capturing edge to Dataout_valid=1.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] mode, input logic [31:0] res, input logic [2:0] exc,
                        input int hold);
    int edges;
    @(negedge CLK);
    Datain1    = a;
    Datain2    = b;
    Mode       = mode;
    Data_valid = 1'b1;
    sb_q.push_back('{res, exc, name});
    edges = 0;
    while (edges < 20 && Dataout_valid !== 1'b1) begin
      @(posedge CLK);
      #1;
      edges++;
    end
    check({name, " latency"}, 32'(edges), 32'd5);
    for (int k = 0; k < hold; k++) begin
      @(posedge CLK);
      #1;
      check({name, " valid_held"}, {31'd0, Dataout_valid}, 32'd1);
    end
    @(negedge CLK);
    Data_valid = 1'b0;
    Datain1    = 32'hDEAD_BEEF;
    Datain2    = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1;
    check({name, " valid_drop"}, {31'd0, Dataout_valid}, 32'd0);
  endtask

  initial begin
    RSTn       = 1'b0;
    Datain1    = 32'd0;
    Datain2    = 32'd0;
    Data_valid = 1'b0;
    Mode       = 3'b000;
    Debug      = 5'b10101;
    #12;
    check("reset dataout", Dataout, 32'd0);
    check("reset valid", {31'd0, Dataout_valid}, 32'd0);
    check("reset exc", {29'd0, Exc}, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;

    run_op("add_same_sign",   32'h4030_0000, 32'h40B0_0000, 3'b000, 32'h4104_0000, 3'b000, 0);
    run_op("sub_neg_smaller", 32'hC030_0000, 32'h40B0_0000, 3'b000, 32'h4030_0000, 3'b000, 0);
    run_op("sub_neg_larger",  32'h4030_0000, 32'hC0B0_0000, 3'b000, 32'hC030_0000, 3'b000, 0);
    run_op("grs_align",       32'h4020_13D3, 32'hC756_D800, 3'b000, 32'hC756_D580, 3'b000, 0);
    run_op("inf_minus_inf",   32'h7F80_0000, 32'hFF80_0000, 3'b000, 32'h7FC0_0000, 3'b011, 0);
    run_op("overflow_rne",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b000, 32'h7F80_0000, 3'b001, 0);
    run_op("overflow_rtz",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b001, 32'h7F7F_FFFF, 3'b001, 0);
    run_op("cancel_rne",      32'h3F80_0000, 32'hBF80_0000, 3'b000, 32'h0000_0000, 3'b000, 0);
    run_op("cancel_rtn",      32'h3F80_0000, 32'hBF80_0000, 3'b011, 32'h8000_0000, 3'b000, 0);
    run_op("neg_zeros",       32'h8000_0000, 32'h8000_0000, 3'b000, 32'h8000_0000, 3'b000, 0);
    run_op("zero_operand",    32'h0000_0000, 32'h3FC0_0000, 3'b000, 32'h3FC0_0000, 3'b000, 0);
    run_op("denormal_zero",   32'h0000_0123, 32'hC040_0000, 3'b000, 32'hC040_0000, 3'b000, 0);
    run_op("nan_input",       32'h7FC0_0001, 32'h3F80_0000, 3'b000, 32'h7FC0_0000, 3'b011, 0);
    run_op("inf_finite",      32'h3F80_0000, 32'hFF80_0000, 3'b000, 32'hFF80_0000, 3'b100, 0);
    run_op("underflow",       32'h0080_0001, 32'h8080_0000, 3'b000, 32'h0000_0000, 3'b010, 0);
    run_op("tie_rne",         32'h3F80_0000, 32'h3380_0000, 3'b000, 32'h3F80_0000, 3'b000, 0);
    run_op("tie_up",          32'h3F80_0000, 32'h3380_0000, 3'b010, 32'h3F80_0001, 3'b000, 0);
`ifdef FPADD_SUBTRACT_EN
    run_op("mode_sub",        32'h4030_0000, 32'h40B0_0000, 3'b100, 32'hC030_0000, 3'b000, 0);
`else
    run_op("mode_sub",        32'h4030_0000, 32'h40B0_0000, 3'b100, 32'h4104_0000, 3'b000, 0);
`endif
    run_op("hold_ack",        32'h4030_0000, 32'h40B0_0000, 3'b000, 32'h4104_0000, 3'b000, 3);

    // Abort while the unit is in NORM: outputs clear at once and no result follows.
    @(negedge CLK);
    Datain1    = 32'h3F80_0000;
    Datain2    = 32'h3F80_0000;
    Mode       = 3'b000;
    Data_valid = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    RSTn = 1'b0;
    #1;
    check("abort dataout", Dataout, 32'd0);
    check("abort valid", {31'd0, Dataout_valid}, 32'd0);
    check("abort exc", {29'd0, Exc}, 32'd0);
    @(negedge CLK);
    Data_valid = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    check("abort no_result", {31'd0, Dataout_valid}, 32'd0);

    run_op("after_reset",     32'h3F80_0000, 32'h3F80_0000, 3'b000, 32'h4000_0000, 3'b000, 0);

    repeat (3) @(posedge CLK);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp32_add_unit.md
Name: fp32_add_unit

Overview:
Single-precision (IEEE-754 binary32) floating-point adder with a request/acknowledge handshake toward the caller. It contains three parts: a multi-cycle control FSM, a 24-bit significand adder and an input exception classifier. It sits in the FPU datapath as the add/subtract execution unit.

Parameters:
- LATENCY, 5: clock edges from Data_valid being sampled high in IDLE to Dataout_valid=1. Fixed; documented only, no other value is supported.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  asynchronous active-low reset.
- Datain1  in  32  operand A, binary32.
- Datain2  in  32  operand B, binary32.
- Data_valid  in  1  request; caller holds it high until Dataout_valid=1.
- Mode  in  3  [1:0] rounding: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf. [2] subtract (see Optional Feature).
- Debug  in  5  reserved; ignored by the logic.
- Dataout  out  32  result, binary32.
- Dataout_valid  out  1  result valid / acknowledge.
- Exc  out  3  exception code for the result.

Behaviour:
- Reset (async, RSTn=0):
  - Dataout=0, Dataout_valid=0, Exc=000.
  - FSM goes to IDLE and internal registers clear.
  - Reset mid-operation aborts the operation; no result is produced.
- FSM states and transitions:
  - IDLE: when Data_valid=1, capture Datain1, Datain2 and Mode; go to ALIGN.
  - ALIGN: unpack operands (hidden bit = 1 for normals); classify special cases; swap so the larger magnitude is operand X; right-shift the smaller significand by the exponent difference into a 27-bit field (24 bits plus guard, round, sticky). Shifts of 26 or more leave only sticky.
  - ADD: same effective sign: X+Y; different effective sign: X−Y. Uses the 24-bit adder with carry-out plus G/R/S extension. Result sign is the sign of X.
  - NORM: if carry-out, shift right 1 and increment the exponent (sticky ORs in the shifted-out bit). Otherwise, left-shift by the leading-zero count (single-cycle priority encoder) and decrement the exponent.
  - ROUND: round per Mode[1:0] using G/R/S; renormalize on mantissa overflow; apply overflow/underflow; register Dataout and Exc; set Dataout_valid=1; go to DONE.
  - DONE: hold Dataout_valid=1 while Data_valid=1. When Data_valid is sampled 0, clear Dataout_valid on that edge and go to IDLE. Dataout and Exc keep their last values.
- Operands change only when captured in IDLE; input changes during computation are ignored.
- Back-to-back operation: a new request is accepted only from IDLE, at the earliest one edge after Dataout_valid falls.
- Exc codes and results:
  - 000: normal result.
  - 001: overflow; result is ±inf (RNE/directed rounding per IEEE; RTZ gives ±max finite 0x7F7FFFFF with sign).
  - 010: underflow; result exponent below 1; flushed to signed zero.
  - 011: invalid; any NaN input or +inf + −inf; Dataout=0x7FC00000.
  - 100: infinite operand with finite or same-sign infinite operand; Dataout = that infinity.
  - Priority: 011 > 100 > 001 > 010.
- Denormal inputs (exponent 0) are treated as signed zero.
- Exact cancellation gives +0 (−0 under round toward −inf). −0 + −0 = −0.
- Zero operand: the result is the other operand exactly.

Optional Feature:
- Macro FPADD_SUBTRACT_EN.
- Defined: Mode[2]=1 inverts the sign of the captured Datain2 before ALIGN, so the unit computes A−B (NaN handling unchanged).
- Not defined: Mode[2] is ignored and the unit always adds.

Test Plan:
- Same sign: 0x40300000 (2.75) + 0x40B00000 (5.5), Mode=0 → Dataout=0x41040000 (8.25), Exc=000, Dataout_valid exactly 5 edges after capture.
- Opposite sign, negative smaller: 0xC0300000 + 0x40B00000 → 0x40300000 (2.75).
- Opposite sign, negative larger: 0x40300000 + 0xC0B00000 → 0xC0300000 (−2.75).
- Large alignment with active G/R/S: 0x402013D3 + 0xC756D800, RNE → 0xC756D580 (−54997.5).
- Specials: 0x7F800000 + 0xFF800000 → 0x7FC00000, Exc=011. 0x7F7FFFFF + 0x7F7FFFFF, RNE → 0x7F800000, Exc=001. 0x3F800000 + 0xBF800000 → 0x00000000, Exc=000.
- Handshake/reset:
  - Hold Data_valid high 3 cycles after Dataout_valid=1 → Dataout_valid stays 1 and falls one edge after Data_valid drops.
  - Assert RSTn=0 during NORM → all outputs 0 immediately, no result produced.
  - A new request afterwards completes normally.
